// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: operation selects, opcode/funct fields,
// and the program-loader FSM state type. The ST_PAD state exists only when
// IMEM_HALT_PAD_EN is defined.
package mips_pkg;

    typedef enum logic [3:0] {
        OPS_ADD  = 4'd0,
        OPS_SUB  = 4'd1,
        OPS_AND  = 4'd2,
        OPS_OR   = 4'd3,
        OPS_SLT  = 4'd4,
        OPS_ADDI = 4'd5,
        OPS_ANDI = 4'd6,
        OPS_BEQ  = 4'd7,
        OPS_BNE  = 4'd8,
        OPS_LW   = 4'd9,
        OPS_SW   = 4'd10,
        OPS_J    = 4'd11
    } op_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
`ifdef IMEM_HALT_PAD_EN
        ST_PAD  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_e;

    // J-format word; also used to build halt self-loops.
    function automatic logic [31:0] j_word(input logic [25:0] tgt);
        return {OP_J, tgt};
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: symbolic instruction fields -> 32-bit MIPS word.
// Unknown operation selects encode as a nop (all zeros) and raise illegal_o.
module instr_encoder
    import mips_pkg::*;
(
    input  logic [3:0]  op_sel_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Field packing by instruction format; fields pass through unmodified.
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_sel_i)
            OPS_ADD:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_ADD};
            OPS_SUB:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_SUB};
            OPS_AND:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_AND};
            OPS_OR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_OR};
            OPS_SLT:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_SLT};
            OPS_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
            OPS_ANDI: word_o = {OP_ANDI, rs_i, rt_i, imm_i};
            OPS_BEQ:  word_o = {OP_BEQ, rs_i, rt_i, imm_i};
            OPS_BNE:  word_o = {OP_BNE, rs_i, rt_i, imm_i};
            OPS_LW:   word_o = {OP_LW, rs_i, rt_i, imm_i};
            OPS_SW:   word_o = {OP_SW, rs_i, rt_i, imm_i};
            OPS_J:    word_o = j_word(target_i);
            default: begin
                word_o    = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader. Encodes a stream of symbolic
// instructions and writes them to imem from address 0, holding the CPU in
// reset until the program is complete.
// Build option: IMEM_HALT_PAD_EN fills the unused tail of imem with
// "j self" halt loops after the last instruction.
module imem_program_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [3:0]    op_sel,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err_illegal,
    output logic          err_overflow
);

    if (AW != $clog2(DEPTH)) begin : g_bad_aw
        $error("AW must equal clog2(DEPTH)");
    end

    // One extra pointer bit so "full" (ptr == DEPTH) is representable
    // without wrapping.
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef IMEM_HALT_PAD_EN
    localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
`endif

    state_e        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ill_q, ill_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          hold_q, hold_d;
    logic          rdy_c;
    logic          full_c;
    logic [31:0]   enc_word;
    logic          enc_ill;

    instr_encoder u_enc (
        .op_sel_i  (op_sel),
        .rs_i      (rs),
        .rt_i      (rt),
        .rd_i      (rd),
        .imm_i     (imm),
        .target_i  (target),
        .word_o    (enc_word),
        .illegal_o (enc_ill)
    );

    assign full_c = (ptr_q == DEPTH_C);

    // Next-state logic: beat acceptance, write generation, padding, errors.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        rdy_c   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                rdy_c = !full_c;
                if (in_valid && !full_c) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[AW-1:0];
                    wdata_d = enc_word;
                    ptr_d   = ptr_q + PTR_ONE;
                    if (enc_ill) begin
                        ill_d = 1'b1;
                    end
                    if (in_last) begin
`ifdef IMEM_HALT_PAD_EN
                        state_d = (ptr_q == LAST_C) ? ST_DONE : ST_PAD;
`else
                        state_d = ST_DONE;
`endif
                    end
                end else if (in_valid && full_c) begin
                    // Program longer than imem: flag it and stop, no write.
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
`ifdef IMEM_HALT_PAD_EN
            ST_PAD: begin
                we_d    = 1'b1;
                addr_d  = ptr_q[AW-1:0];
                wdata_d = j_word(26'(ptr_q[AW-1:0]));
                ptr_d   = ptr_q + PTR_ONE;
                if (ptr_q == LAST_C) begin
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // done/cpu_hold lag entry into DONE by one cycle so the final write
        // has landed before the CPU is released; a restart drops them at once.
        done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        hold_d = !done_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign in_ready     = rdy_c;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;

endmodule
